ahb_sram_slave: RTL and testbench

//  AHB-Lite responder for on-chip SRAM; the completer end of the bus driven by the core's AHB master bridge.

---
 rtl/ahb_sram_slave_pkg.sv | 38 +++
 rtl/ahb_sram_slave_if.sv | 26 ++
 rtl/ahb_sram_slave_byte_lane_dec.sv | 27 ++
 rtl/ahb_sram_slave.sv | 107 ++++++++++
 tb/tb_ahb_sram_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and SRAM-slave state type.
// The AHB_SRAM_ERR_EN macro adds the two-cycle ERROR response states.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_ACC, ST_RDATA, ST_ERR1, ST_ERR2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_WAIT, ST_ACC, ST_RDATA
    } state_e;
`endif

    // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY get a zero-wait OKAY.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle; the master modport drives address/control/write data.
interface ahb_sram_slave_if;

    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [2:0]  S_HBURST;
    logic        S_HWRITE;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [1:0]  S_HRESP;
    logic [31:0] S_HRDATA;

    modport master (
        output S_HSEL, S_HADDR, S_HTRANS, S_HSIZE, S_HBURST, S_HWRITE, S_HWDATA, S_HREADY,
        input  S_HREADYOUT, S_HRESP, S_HRDATA
    );

    modport slave (
        input  S_HSEL, S_HADDR, S_HTRANS, S_HSIZE, S_HBURST, S_HWRITE, S_HWDATA, S_HREADY,
        output S_HREADYOUT, S_HRESP, S_HRDATA
    );

endinterface

// File: rtl/ahb_sram_slave_byte_lane_dec.sv
// AHB byte-lane decoder: (hsize, addr[1:0]) -> byte enables plus an unsupported-access flag.
// Byte enables ignore sub-size address bits, so a misaligned access lands on its aligned lanes.
module ahb_byte_lane_dec
    import ahb_sram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misalign
);

    always_comb begin
        be       = '1;
        misalign = 1'b0;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                misalign = addr[0];
            end
            HSIZE_WORD: misalign = (addr != 2'b00);
            // Sizes wider than a word are flagged but otherwise treated as a word.
            default:    misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for single-port on-chip SRAM with WAIT_CYCLES wait states per access.
// Define AHB_SRAM_ERR_EN to answer misaligned/oversized transfers with a two-cycle ERROR.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    ahb_sram_slave_if.slave   bus,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic              write_q;
    logic              hreadyout;
    logic [3:0]        lane_be;
    logic              lane_misalign;
    logic              accept;

    ahb_byte_lane_dec u_lane_dec (
        .hsize    (bus.S_HSIZE),
        .addr     (bus.S_HADDR[1:0]),
        .be       (lane_be),
        .misalign (lane_misalign)
    );

    assign accept = bus.S_HSEL & is_active(bus.S_HTRANS) & bus.S_HREADY & hreadyout;

    // Byte enables are decoded at accept time so the data phase needs no size register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            hreadyout <= 1'b1;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
                state     <= ST_ACC;
                hreadyout <= write_q;
            end
        end else if (state == ST_ACC && !write_q) begin
            state     <= ST_RDATA;
            hreadyout <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            hreadyout <= 1'b1;
`endif
        end else if (accept) begin
            addr_q  <= bus.S_HADDR[ADDR_W+1:2];
            be_q    <= lane_be;
            write_q <= bus.S_HWRITE;
`ifdef AHB_SRAM_ERR_EN
            if (lane_misalign) begin
                state     <= ST_ERR1;
                hreadyout <= 1'b0;
            end else
`endif
            if (WAIT_CYCLES != 0) begin
                state     <= ST_WAIT;
                cnt       <= 3'(WAIT_CYCLES);
                hreadyout <= 1'b0;
            end else begin
                state     <= ST_ACC;
                hreadyout <= bus.S_HWRITE;
            end
        end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
        end
    end

    assign mem_ce    = (state == ST_ACC);
    assign mem_we    = mem_ce & write_q;
    assign mem_addr  = mem_ce ? addr_q : '0;
    assign mem_be    = mem_ce ? be_q : '0;
    assign mem_wdata = mem_we ? bus.S_HWDATA : '0;

    assign bus.S_HREADYOUT = hreadyout;
    assign bus.S_HRDATA    = (state == ST_RDATA) ? mem_rdata : '0;
`ifdef AHB_SRAM_ERR_EN
    assign bus.S_HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign bus.S_HRESP = HRESP_OKAY;
`endif

    logic unused_bus;
`ifdef AHB_SRAM_ERR_EN
    assign unused_bus = ^{bus.S_HBURST, bus.S_HADDR[31:ADDR_W+2]};
`else
    assign unused_bus = ^{bus.S_HBURST, bus.S_HADDR[31:ADDR_W+2], lane_misalign};
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait instance driven from a vector table,
// and a WAIT_CYCLES=3 instance exercised with hand-written wait/BUSY/reset sequences.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        ce;
        logic        we;
        logic [13:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   we_cnt1 = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();
    assign bus0.S_HREADY = bus0.S_HREADYOUT;
    assign bus1.S_HREADY = bus1.S_HREADYOUT;

    logic        ce0, we0, ce1, we1;
    logic [13:0] addr0, addr1;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, rdata0, rdata1;
    logic [31:0] sram0 [0:16383];
    logic [31:0] sram1 [0:16383];

    ahb_sram_slave #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0),
        .mem_ce(ce0), .mem_we(we0), .mem_addr(addr0), .mem_be(be0),
        .mem_wdata(wdata0), .mem_rdata(rdata0)
    );

    ahb_sram_slave #(.ADDR_W(14), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .mem_ce(ce1), .mem_we(we1), .mem_addr(addr1), .mem_be(be1),
        .mem_wdata(wdata1), .mem_rdata(rdata1)
    );

    // Single-port SRAM models: byte-masked write, read data valid the cycle after ce.
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) begin
                if (be0[0]) sram0[addr0][7:0]   <= wdata0[7:0];
                if (be0[1]) sram0[addr0][15:8]  <= wdata0[15:8];
                if (be0[2]) sram0[addr0][23:16] <= wdata0[23:16];
                if (be0[3]) sram0[addr0][31:24] <= wdata0[31:24];
            end else begin
                rdata0 <= sram0[addr0];
            end
        end
        if (ce1) begin
            if (we1) begin
                if (be1[0]) sram1[addr1][7:0]   <= wdata1[7:0];
                if (be1[1]) sram1[addr1][15:8]  <= wdata1[15:8];
                if (be1[2]) sram1[addr1][23:16] <= wdata1[23:16];
                if (be1[3]) sram1[addr1][31:24] <= wdata1[31:24];
            end else begin
                rdata1 <= sram1[addr1];
            end
        end
        if (we1) we_cnt1 <= we_cnt1 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                                input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                                input logic rdy, input logic [1:0] rs, input logic [31:0] rd,
                                input logic ce, input logic we, input logic [13:0] ma,
                                input logic [3:0] be, input logic [31:0] mwd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.addr = a; v.size = sz; v.write = wr; v.wdata = wd;
        v.rdy = rdy; v.resp = rs; v.rdata = rd; v.ce = ce; v.we = we; v.maddr = ma;
        v.be = be; v.mwdata = mwd;
        return v;
    endfunction

    task automatic drv1(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        bus1.S_HSEL   = sel;
        bus1.S_HTRANS = tr;
        bus1.S_HADDR  = a;
        bus1.S_HSIZE  = sz;
        bus1.S_HWRITE = wr;
        bus1.S_HWDATA = wd;
        @(negedge clk);
    endtask

    // Holds the given address-phase signals until dut1 raises HREADYOUT; counts wait cycles.
    task automatic wait_rdy1(input string name, input logic [1:0] tr, input logic [31:0] a,
                             input logic wr, input logic [31:0] wd, output int lows);
        bit done;
        done = 1'b0;
        lows = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            drv1(tr != ID, tr, a, W, wr, wd);
            if (bus1.S_HREADYOUT === 1'b1) done = 1'b1;
            else lows++;
        end
        if (!done) chk({name, "_ready_timeout"}, 32'(lows), 32'd0);
    endtask

    vec_t vt[$];
    int   lows;
    int   we_base;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.S_HSEL = 1'b0; bus0.S_HTRANS = ID; bus0.S_HADDR = '0; bus0.S_HSIZE = W;
        bus0.S_HBURST = 3'b000; bus0.S_HWRITE = 1'b0; bus0.S_HWDATA = '0;
        bus1.S_HSEL = 1'b0; bus1.S_HTRANS = ID; bus1.S_HADDR = '0; bus1.S_HSIZE = W;
        bus1.S_HBURST = 3'b001; bus1.S_HWRITE = 1'b0; bus1.S_HWDATA = '0;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        chk("rst_readyout", 32'(bus0.S_HREADYOUT), 32'd1);
        chk("rst_resp", 32'(bus0.S_HRESP), 32'd0);
        chk("rst_rdata", bus0.S_HRDATA, 32'd0);
        chk("rst_mem", {11'd0, ce0, we0, addr0, be0, 1'b0}, 32'd0);
        chk("rst_wdata", wdata0, 32'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;

        //                sel tr  addr          sz wr wdata          rdy rs rdata         ce we ma     be    mwdata
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, NS, 32'h10, W, 1, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'hDEADBEEF, 1, 0, 32'h0,        1, 1, 14'h4, 4'hF, 32'hDEADBEEF));
        vt.push_back(mk(1, NS, 32'h10, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h4, 4'hF, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'hDEADBEEF, 0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, NS, 32'h13, B, 1, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, SQ, 32'h16, H, 1, 32'hAB000000, 1, 0, 32'h0,        1, 1, 14'h4, 4'h8, 32'hAB000000));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h12340000, 1, 0, 32'h0,        1, 1, 14'h5, 4'hC, 32'h12340000));
        vt.push_back(mk(1, NS, 32'h10, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h4, 4'hF, 32'h0));
        vt.push_back(mk(1, NS, 32'h10, W, 0, 32'h0,        1, 0, 32'hABADBEEF, 0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h4, 4'hF, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'hABADBEEF, 0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, BZ, 32'h10, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, NS, 32'h20, W, 1, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h5A5A0F0F, 1, 0, 32'h0,        1, 1, 14'h8, 4'hF, 32'h5A5A0F0F));
        vt.push_back(mk(1, NS, 32'h21, B, 1, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, NS, 32'h20, H, 1, 32'h00007700, 1, 0, 32'h0,        1, 1, 14'h8, 4'h2, 32'h00007700));
        vt.push_back(mk(1, NS, 32'h20, W, 0, 32'h00001111, 1, 0, 32'h0,        1, 1, 14'h8, 4'h3, 32'h00001111));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h8, 4'hF, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'h5A5A1111, 0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, NS, 32'h00, W, 1, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'hCAFEF00D, 1, 0, 32'h0,        1, 1, 14'h0, 4'hF, 32'hCAFEF00D));
        vt.push_back(mk(1, NS, 32'h02, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
`ifdef AHB_SRAM_ERR_EN
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 1, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 1, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
`else
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h0, 4'hF, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'hCAFEF00D, 0, 0, 14'h0, 4'h0, 32'h0));
`endif
        vt.push_back(mk(1, NS, 32'h00, 3'b011, 0, 32'h0,   1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
`ifdef AHB_SRAM_ERR_EN
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 1, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 1, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));
`else
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        0, 0, 32'h0,        1, 0, 14'h0, 4'hF, 32'h0));
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'hCAFEF00D, 0, 0, 14'h0, 4'h0, 32'h0));
`endif
        vt.push_back(mk(0, ID, 32'h00, W, 0, 32'h0,        1, 0, 32'h0,        0, 0, 14'h0, 4'h0, 32'h0));

        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            bus0.S_HSEL   = vt[i].sel;
            bus0.S_HTRANS = vt[i].trans;
            bus0.S_HADDR  = vt[i].addr;
            bus0.S_HSIZE  = vt[i].size;
            bus0.S_HWRITE = vt[i].write;
            bus0.S_HWDATA = vt[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_readyout", i), 32'(bus0.S_HREADYOUT), 32'(vt[i].rdy));
            chk($sformatf("v%0d_resp", i), 32'(bus0.S_HRESP), 32'(vt[i].resp));
            chk($sformatf("v%0d_rdata", i), bus0.S_HRDATA, vt[i].rdata);
            chk($sformatf("v%0d_ce", i), 32'(ce0), 32'(vt[i].ce));
            chk($sformatf("v%0d_we", i), 32'(we0), 32'(vt[i].we));
            chk($sformatf("v%0d_addr", i), 32'(addr0), 32'(vt[i].maddr));
            chk($sformatf("v%0d_be", i), 32'(be0), 32'(vt[i].be));
            chk($sformatf("v%0d_wdata", i), wdata0, vt[i].mwdata);
        end

        // WAIT_CYCLES=3: writes stall 3 cycles, reads 4, then data.
        drv1(1, NS, 32'h40, W, 1, 32'h0);
        wait_rdy1("w3_wr40", ID, 32'h0, 0, 32'h01234567, lows);
        chk("w3_wr40_waits", 32'(lows), 32'd3);
        chk("w3_wr40_we", 32'(we1), 32'd1);
        chk("w3_wr40_addr", 32'(addr1), 32'h10);
        chk("w3_wr40_wdata", wdata1, 32'h01234567);

        drv1(1, NS, 32'h44, W, 1, 32'h0);
        wait_rdy1("w3_wr44", ID, 32'h0, 0, 32'h89ABCDEF, lows);
        chk("w3_wr44_waits", 32'(lows), 32'd3);

        drv1(1, NS, 32'h40, W, 0, 32'h0);
        wait_rdy1("w3_rd40", ID, 32'h0, 0, 32'h0, lows);
        chk("w3_rd40_waits", 32'(lows), 32'd4);
        chk("w3_rd40_rdata", bus1.S_HRDATA, 32'h01234567);
        chk("w3_rd40_resp", 32'(bus1.S_HRESP), 32'd0);

        // INCR burst with a BUSY beat: no SRAM access while BUSY, then the SEQ beat completes.
        drv1(1, NS, 32'h40, W, 0, 32'h0);
        wait_rdy1("burst_b0", BZ, 32'h44, 0, 32'h0, lows);
        chk("burst_b0_rdata", bus1.S_HRDATA, 32'h01234567);
        for (int k = 0; k < 3; k++) begin
            drv1(1, BZ, 32'h44, W, 0, 32'h0);
            chk($sformatf("busy%0d_ce", k), 32'(ce1), 32'd0);
            chk($sformatf("busy%0d_readyout", k), 32'(bus1.S_HREADYOUT), 32'd1);
            chk($sformatf("busy%0d_resp", k), 32'(bus1.S_HRESP), 32'd0);
        end
        drv1(1, SQ, 32'h44, W, 0, 32'h0);
        wait_rdy1("burst_b1", ID, 32'h0, 0, 32'h0, lows);
        chk("burst_b1_waits", 32'(lows), 32'd4);
        chk("burst_b1_rdata", bus1.S_HRDATA, 32'h89ABCDEF);

        // Reset during the wait states of a write must drop it without touching the SRAM.
        drv1(1, NS, 32'h48, W, 1, 32'h0);
        wait_rdy1("pre_wr48", ID, 32'h0, 0, 32'h11112222, lows);
        drv1(0, ID, 32'h0, W, 0, 32'h0);
        we_base = we_cnt1;
        drv1(1, NS, 32'h48, W, 1, 32'h0);
        drv1(0, ID, 32'h0, W, 0, 32'hBAD0BAD0);
        chk("abort_in_wait", 32'(bus1.S_HREADYOUT), 32'd0);
        #2 rst1 = 1'b0;
        #1;
        chk("abort_rst_readyout", 32'(bus1.S_HREADYOUT), 32'd1);
        chk("abort_rst_resp", 32'(bus1.S_HRESP), 32'd0);
        chk("abort_rst_rdata", bus1.S_HRDATA, 32'd0);
        chk("abort_rst_mem", {11'd0, ce1, we1, addr1, be1, 1'b0}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst1 = 1'b1;
        repeat (4) drv1(0, ID, 32'h0, W, 0, 32'hBAD0BAD0);
        chk("abort_no_write", 32'(we_cnt1 - we_base), 32'd0);
        drv1(1, NS, 32'h48, W, 0, 32'h0);
        wait_rdy1("post_rd48", ID, 32'h0, 0, 32'h0, lows);
        chk("post_rd48_waits", 32'(lows), 32'd4);
        chk("post_rd48_rdata", bus1.S_HRDATA, 32'h11112222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
